// File: rtl/lcd_cmd_seq.sv
// Replays a command script from a synchronous command ROM into the LCD controller,
// one opcode per strobe, finishing on the controller's done or a watchdog timeout.
module lcd_cmd_seq #(
  parameter int CMD_DEPTH = 64,
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        CROM_Q,
  output logic              CROM_rd,
  output logic [ADDR_W-1:0] CROM_A,
  input  logic              busy,
  input  logic              done,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [6:0]        cmd_cnt,
  output logic              err,
  output logic [2:0]        dbg_state_o
);

  localparam int WDOG_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_SEND      = 3'd4,
    S_NEXT      = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_FIN       = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   crom_a_q, crom_a_d;
  logic [3:0]          op_q, op_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [6:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wrap_q, wrap_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;

  // Pointer advance is modulo CMD_DEPTH; wrap_q remembers that the script ran off its end.
  logic [ADDR_W-1:0]   ptr_inc;
  logic                ptr_at_end;

  assign ptr_at_end = (ptr_q == ADDR_W'(CMD_DEPTH - 1));
  assign ptr_inc    = ptr_at_end ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      crom_a_q <= '0;
      op_q     <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      crom_a_q <= crom_a_d;
      op_q     <= op_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    crom_a_d = crom_a_q;
    op_d     = op_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wrap_d   = wrap_q;
    wdog_d   = wdog_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          crom_a_d = ptr_q;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        op_d = CROM_Q;
        // Opcodes 12..15 are not understood by the controller and are dropped.
        if (CROM_Q >= 4'd12) begin
          err_d   = 1'b1;
          ptr_d   = ptr_inc;
          wrap_d  = wrap_q | ptr_at_end;
          state_d = S_NEXT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!busy) begin
          cmd_d   = op_q;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
        if (op_q == 4'd0) begin
          wdog_d  = '0;
          state_d = S_WAIT_DONE;
        end else begin
          ptr_d   = ptr_inc;
          wrap_d  = wrap_q | ptr_at_end;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // A script without WRITE gets one forced in after a full pass.
        if (wrap_q) begin
          err_d   = 1'b1;
          op_d    = 4'd0;
          wrap_d  = 1'b0;
          state_d = S_ISSUE;
        end else begin
          crom_a_d = ptr_q;
          state_d  = S_FETCH;
        end
      end
      S_WAIT_DONE: begin
        wdog_d = wdog_q + 1'b1;
        if (done) begin
          state_d = S_FIN;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_FIN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign CROM_rd     = (state_q == S_FETCH);
  assign CROM_A      = crom_a_q;
  assign cmd         = cmd_q;
  assign cmd_valid   = (state_q == S_SEND);
  assign seq_busy    = (state_q != S_IDLE) && (state_q != S_FIN);
  assign seq_done    = (state_q == S_FIN);
  assign cmd_cnt     = cnt_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: a script-walking timing model predicts every output
// on every cycle; literal expectations pin key latencies and counts.
module tb_lcd_cmd_seq;

  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 1024;
  localparam int MAXC    = 1200;
  localparam int NEVER   = 1000000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset, start, busy, done;
  logic [3:0] CROM_Q;
  logic       CROM_rd, cmd_valid, seq_busy, seq_done, err;
  logic [5:0] CROM_A;
  logic [3:0] cmd;
  logic [6:0] cmd_cnt;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  lcd_cmd_seq #(.CMD_DEPTH(DEPTH), .ADDR_W(6), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .CROM_Q(CROM_Q), .CROM_rd(CROM_rd),
    .CROM_A(CROM_A), .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
    .seq_busy(seq_busy), .seq_done(seq_done), .cmd_cnt(cmd_cnt), .err(err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- model state ----------------
  logic [3:0] rom [DEPTH];
  int busy_until, done_at, reset_at;
  int m_fin, m_ecyc, m_ncyc;
  bit e_valid [MAXC];
  bit e_rd    [MAXC];
  int e_a     [MAXC];
  int e_op    [MAXC];
  int e_cmd   [MAXC];
  int e_cnt   [MAXC];
  bit e_err   [MAXC];
  bit e_done  [MAXC];
  bit e_sbusy [MAXC];

  int checks = 0;
  int failures = 0;
  int rel = 0;
  bit active = 0;
  bit pend_rd;
  int pend_a;

  // observations of the DUT, used by the literal pins
  int obs_v_q[$];
  int obs_cmd_q[$];
  int obs_done, obs_err, last_cnt, last_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, rel, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Walks the script: each command costs FETCH/LATCH/ISSUE(+busy wait)/SEND/NEXT,
  // an illegal opcode costs FETCH/LATCH/NEXT, an overrun forces a WRITE from NEXT.
  task automatic build_model();
    int t, idx, c, s, w, dv, cnt, last;
    int op;
    for (int k = 0; k < MAXC; k++) begin
      e_valid[k] = 0; e_rd[k] = 0; e_a[k] = 0; e_op[k] = 0;
    end
    t = 0; idx = 0; s = 0; m_ecyc = MAXC;
    for (int guard = 0; guard < 200; guard++) begin
      if (idx == DEPTH) begin
        if (t + 1 < m_ecyc) m_ecyc = t + 1;
        op = 0;
        c = imax(t + 1, busy_until);
      end else begin
        e_rd[t+1] = 1; e_a[t+1] = idx;
        op = int'(rom[idx]);
        if (op >= 12) begin
          if (t + 3 < m_ecyc) m_ecyc = t + 3;
          idx++;
          t = t + 3;
          continue;
        end
        c = imax(t + 3, busy_until);
      end
      s = c + 1;
      e_valid[s] = 1; e_op[s] = op;
      if (op == 0) break;
      idx++;
      t = s + 1;
    end
    w  = s + 1;
    dv = imax(done_at, w);
    if (dv <= w + TIMEOUT - 1) m_fin = dv + 1;
    else begin
      m_fin = w + TIMEOUT;
      if (m_fin < m_ecyc) m_ecyc = m_fin;
    end
    m_ncyc = (reset_at >= 0) ? reset_at + 4 : m_fin + 3;
    cnt = 0; last = 0;
    for (int k = 0; k < m_ncyc; k++) begin
      e_cnt[k] = cnt;
      if (e_valid[k]) begin
        last = e_op[k];
        if (cnt < 127) cnt++;
      end
      e_cmd[k]   = last;
      e_err[k]   = (k >= m_ecyc);
      e_done[k]  = (k >= m_fin);
      e_sbusy[k] = (k >= 1) && (k < m_fin);
      if (reset_at >= 0 && k > reset_at) begin
        e_cnt[k] = 0; e_cmd[k] = 0; e_err[k] = 0; e_done[k] = 0;
        e_sbusy[k] = 0; e_valid[k] = 0; e_rd[k] = 0;
      end
    end
  endtask

  // ---------------- scoreboard compare, every cycle of a run ----------------
  always @(negedge clk) begin
    if (active) begin
      chk("cmd_valid", int'(cmd_valid), int'(e_valid[rel]));
      chk("cmd", int'(cmd), e_cmd[rel]);
      chk("cmd_cnt", int'(cmd_cnt), e_cnt[rel]);
      chk("err", int'(err), int'(e_err[rel]));
      chk("seq_done", int'(seq_done), int'(e_done[rel]));
      chk("seq_busy", int'(seq_busy), int'(e_sbusy[rel]));
      chk("CROM_rd", int'(CROM_rd), int'(e_rd[rel]));
      if (e_rd[rel]) chk("CROM_A", int'(CROM_A), e_a[rel]);
      if (cmd_valid) begin
        obs_v_q.push_back(rel);
        obs_cmd_q.push_back(int'(cmd));
      end
      if (seq_done && obs_done < 0) obs_done = rel;
      if (err && obs_err < 0) obs_err = rel;
      last_cnt = int'(cmd_cnt);
      last_err = int'(err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; busy = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_cmd_cnt", int'(cmd_cnt), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_seq_busy", int'(seq_busy), 0);
    chk("rst_seq_done", int'(seq_done), 0);
    chk("rst_CROM_rd", int'(CROM_rd), 0);
    chk("rst_CROM_A", int'(CROM_A), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    pend_rd = 1'b0; pend_a = 0;
  endtask

  task automatic load_rom(input int n, input int v0, input int v1, input int v2, input int v3);
    int vals [4];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int i = 0; i < DEPTH; i++) rom[i] = 4'd0;
    for (int i = 0; i < n; i++) rom[i] = 4'(vals[i]);
  endtask

  task automatic run_test();
    build_model();
    obs_v_q.delete(); obs_cmd_q.delete();
    obs_done = -1; obs_err = -1;
    for (int k = 0; k < m_ncyc; k++) begin
      @(posedge clk); #1;
      if (pend_rd) CROM_Q = rom[pend_a];
      rel   = k;
      start = (k == 0);
      busy  = (k < busy_until);
      done  = (k >= done_at);
      reset = (k == reset_at);
      active = 1'b1;
      pend_rd = CROM_rd;
      pend_a  = int'(CROM_A);
    end
    @(negedge clk); #1;
    active = 1'b0;
    reset = 1'b0; start = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1; start = 1'b0; busy = 1'b0; done = 1'b0; CROM_Q = 4'd0;
    pend_rd = 1'b0; pend_a = 0;

    // T1: {4,1,7,0}, done at 25
    do_reset();
    load_rom(4, 4, 1, 7, 0);
    busy_until = 0; done_at = 25; reset_at = -1;
    run_test();
    chk("t1_model_fin", m_fin, 26);
    chk("t1_nvalid", obs_v_q.size(), 4);
    if (obs_v_q.size() == 4) begin
      chk("t1_v0", obs_v_q[0], 4);   chk("t1_v1", obs_v_q[1], 9);
      chk("t1_v2", obs_v_q[2], 14);  chk("t1_v3", obs_v_q[3], 19);
      chk("t1_c0", obs_cmd_q[0], 4); chk("t1_c1", obs_cmd_q[1], 1);
      chk("t1_c2", obs_cmd_q[2], 7); chk("t1_c3", obs_cmd_q[3], 0);
    end
    chk("t1_done_cyc", obs_done, 26);
    chk("t1_cnt", last_cnt, 4);
    chk("t1_err", last_err, 0);

    // T2: {5,0}, busy held through cycle 20; done in first WAIT_DONE cycle
    do_reset();
    load_rom(2, 5, 0, 0, 0);
    busy_until = 21; done_at = 28; reset_at = -1;
    run_test();
    chk("t2_first_valid", (obs_v_q.size() > 0) ? obs_v_q[0] : -1, 22);
    chk("t2_done_cyc", obs_done, 29);
    chk("t2_cnt", last_cnt, 2);

    // T3: {13,2,0}: illegal opcode skipped
    do_reset();
    load_rom(3, 13, 2, 0, 0);
    busy_until = 0; done_at = 16; reset_at = -1;
    run_test();
    chk("t3_err_cyc", obs_err, 3);
    chk("t3_nvalid", obs_v_q.size(), 2);
    if (obs_cmd_q.size() == 2) begin
      chk("t3_c0", obs_cmd_q[0], 2);
      chk("t3_c1", obs_cmd_q[1], 0);
    end
    chk("t3_cnt", last_cnt, 2);

    // T4: 64 x LEFT(3), no WRITE: forced WRITE after overrun
    do_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = 4'd3;
    busy_until = 0; done_at = 400; reset_at = -1;
    run_test();
    chk("t4_nvalid", obs_v_q.size(), 65);
    chk("t4_last_cmd", (obs_cmd_q.size() > 0) ? obs_cmd_q[obs_cmd_q.size()-1] : -1, 0);
    chk("t4_last_valid", (obs_v_q.size() > 0) ? obs_v_q[obs_v_q.size()-1] : -1, 322);
    chk("t4_cnt", last_cnt, 65);
    chk("t4_err", last_err, 1);

    // T5: {0}, done never: watchdog ends it 1024 cycles after WAIT_DONE entry (cycle 5)
    do_reset();
    load_rom(1, 0, 0, 0, 0);
    busy_until = 0; done_at = NEVER; reset_at = -1;
    run_test();
    chk("t5_done_cyc", obs_done, 1029);
    chk("t5_err", last_err, 1);

    // T6: done and watchdog expiry in the same cycle: done wins
    do_reset();
    load_rom(1, 0, 0, 0, 0);
    busy_until = 0; done_at = 1028; reset_at = -1;
    run_test();
    chk("t6_done_cyc", obs_done, 1029);
    chk("t6_err", last_err, 0);

    // T7: reset during ISSUE of the 2nd command (cycle 8), then a clean replay
    do_reset();
    load_rom(4, 4, 1, 7, 0);
    busy_until = 0; done_at = 25; reset_at = 8;
    run_test();
    chk("t7_nvalid", obs_v_q.size(), 1);
    chk("t7_cnt_after_rst", last_cnt, 0);
    reset_at = -1;
    run_test();
    chk("t7_replay_first", (obs_v_q.size() > 0) ? obs_v_q[0] : -1, 4);
    chk("t7_replay_cmd0", (obs_cmd_q.size() > 0) ? obs_cmd_q[0] : -1, 4);
    chk("t7_replay_cnt", last_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
